oled_frame_arbiter: RTL and testbench

- Parametrised N-source pixel arbiter between screen generators (menu, board, game-over, …) and the Oled_Display driver, in the 6.25 MHz pixel clock domain.
- Replaces the single start-bit 2:1 mux.
- Source changes are deferred to a frame boundary, so a frame never shows mixed content except during a deliberate transition.
- Supports hard cut or an animated left-to-right column wipe.

---
 rtl/oled_pkg.sv | 41 ++++
 rtl/oled_frame_arbiter_if.sv | 39 +++
 rtl/oled_idx_to_xy.sv | 27 ++
 rtl/oled_frame_arbiter.sv | 168 ++++++++++++++++
 tb/tb_oled_frame_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oled_pkg
//  Brief    : Shared OLED constants, RGB565 colours, arbiter state and modes
//  Revision : 1.0  initial release
// ============================================================================
package oled_pkg;

  // Display geometry of the 96x64 OLED panel
  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_IDX_W  = 13;

  // RGB565 colour constants
  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;

  // Transition style, latched when a switch request is accepted
  localparam logic MODE_CUT  = 1'b0;
  localparam logic MODE_WIPE = 1'b1;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WIPE = 2'd2
  } arb_state_t;

  // Width of a source selector for n sources (never below one bit)
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : oled_frame_arbiter_if
//  Brief    : Pixel-source / driver bundle around the frame arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface oled_frame_arbiter_if
  import oled_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PIX_W   = 16,
  parameter int IDX_W   = OLED_IDX_W
);
  localparam int SEL_W = sel_width(NUM_SRC);

  logic                     frame_begin;
  logic [IDX_W-1:0]         pixel_index;
  logic [NUM_SRC*PIX_W-1:0] src_data;
  logic [SEL_W-1:0]         sel;
  logic                     mode;
  logic [PIX_W-1:0]         pixel_data;
  logic [SEL_W-1:0]         active_src;
  logic                     busy;
  logic                     switch_done;

  // Environment side: display timing, screen generators and the selector
  modport master (
    output frame_begin, pixel_index, src_data, sel, mode,
    input  pixel_data, active_src, busy, switch_done
  );

  // Arbiter side
  modport slave (
    input  frame_begin, pixel_index, src_data, sel, mode,
    output pixel_data, active_src, busy, switch_done
  );

endinterface
`default_nettype wire

// File: rtl/oled_idx_to_xy.sv
`default_nettype none
// ============================================================================
//  Module   : oled_idx_to_xy
//  Brief    : Linear pixel index to column/row, purely combinational
//  Revision : 1.0  initial release
// ============================================================================
module oled_idx_to_xy
  import oled_pkg::*;
#(
  parameter int WIDTH  = OLED_WIDTH,
  parameter int HEIGHT = OLED_HEIGHT,
  parameter int IDX_W  = OLED_IDX_W,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic [IDX_W-1:0] pixel_index,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  // Divide at 32 bits so the full index range never truncates before the
  // result is narrowed to the column/row widths.
  assign col = COL_W'(32'(pixel_index) % WIDTH);
  assign row = ROW_W'(32'(pixel_index) / WIDTH);

endmodule
`default_nettype wire

// File: rtl/oled_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : oled_frame_arbiter
//  Brief    : N-source pixel arbiter; source changes commit on a frame
//             boundary as a hard cut or a left-to-right column wipe
//  Revision : 1.0  initial release
// ============================================================================
module oled_frame_arbiter
  import oled_pkg::*;
#(
  parameter int              NUM_SRC   = 4,
  parameter int              PIX_W     = 16,
  parameter int              WIDTH     = OLED_WIDTH,
  parameter int              HEIGHT    = OLED_HEIGHT,
  parameter int              IDX_W     = OLED_IDX_W,
  parameter int              WIPE_STEP = 8,
  parameter logic [PIX_W-1:0] BG_COLOUR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  oled_frame_arbiter_if.slave   bus
);

  localparam int SEL_W = sel_width(NUM_SRC);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  // Wide enough to hold the last step past WIDTH without wrapping
  localparam int BND_W = $clog2(WIDTH + WIPE_STEP);
  localparam logic [BND_W-1:0] BND_STEP  = BND_W'(WIPE_STEP);
  localparam logic [BND_W-1:0] BND_LIMIT = BND_W'(WIDTH);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_cur;
  logic [SEL_W-1:0] r_nxt;
  logic [SEL_W-1:0] r_pending;
  logic             r_mode;
  logic [BND_W-1:0] r_boundary;
  logic [PIX_W-1:0] r_pixel;
  logic             r_busy;
  logic             r_done;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row_unused;
  logic [PIX_W-1:0] w_src [NUM_SRC];
  logic [SEL_W-1:0] w_chosen;
  logic [PIX_W-1:0] w_pix;
  logic             w_sel_valid;
  logic [SEL_W-1:0] w_pend_eff;
  logic [BND_W-1:0] w_bnd_next;

  oled_idx_to_xy #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .IDX_W (IDX_W),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_idx_to_xy (
    .pixel_index(bus.pixel_index),
    .col        (w_col),
    .row        (w_row_unused)
  );

  // Unpack the flat source bus into one word per source
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_src[k] = bus.src_data[k*PIX_W +: PIX_W];
  end

  // Out-of-range selectors are never accepted as requests
  assign w_sel_valid = (int'(bus.sel) < NUM_SRC);
  // While pending, the newest valid request replaces the stored one
  assign w_pend_eff  = w_sel_valid ? bus.sel : r_pending;
  assign w_bnd_next  = r_boundary + BND_STEP;

  // Columns left of the wipe boundary already show the incoming source
  always_comb begin
    w_chosen = r_cur;
    if ((r_state == ST_WIPE) && (BND_W'(w_col) < r_boundary))
      w_chosen = r_nxt;
  end

  // Source mux with background fallback for an invalid selection
  always_comb begin
    w_pix = BG_COLOUR;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_chosen == SEL_W'(k))
        w_pix = w_src[k];
    end
  end

  // Registered pixel output, one clock of latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_pixel <= '0;
    else
      r_pixel <= w_pix;
  end

  // Switch control: request capture, frame-aligned commit and wipe stepping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_pending  <= '0;
      r_mode     <= MODE_CUT;
      r_boundary <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // frame_begin is deliberately ignored here so a request seen in
          // the same cycle waits a whole frame before committing
          if (w_sel_valid && (bus.sel != r_cur)) begin
            r_pending <= bus.sel;
            r_mode    <= bus.mode;
            r_state   <= ST_PEND;
            r_busy    <= 1'b1;
          end
        end
        ST_PEND: begin
          if (bus.sel == r_cur) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.frame_begin) begin
            if (r_mode == MODE_WIPE) begin
              r_nxt      <= w_pend_eff;
              r_boundary <= '0;
              r_state    <= ST_WIPE;
            end else begin
              r_cur   <= w_pend_eff;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_pending <= w_pend_eff;
          end
        end
        ST_WIPE: begin
          if (bus.frame_begin) begin
            if (w_bnd_next >= BND_LIMIT) begin
              r_cur      <= r_nxt;
              r_boundary <= '0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_boundary <= w_bnd_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel_data  = r_pixel;
  assign bus.active_src  = r_cur;
  assign bus.busy        = r_busy;
  assign bus.switch_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_frame_arbiter
//  Brief    : Directed self-checking bench for oled_frame_arbiter
//  Revision : 1.0  initial release
// ============================================================================
module tb_oled_frame_arbiter;

  logic clock;
  logic reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Main arbiter: four sources
  oled_frame_arbiter_if #(.NUM_SRC(4), .PIX_W(16), .IDX_W(13)) bus_a ();
  // Three-source arbiter: selector value 3 is representable but invalid
  oled_frame_arbiter_if #(.NUM_SRC(3), .PIX_W(16), .IDX_W(13)) bus_b ();

  oled_frame_arbiter #(.NUM_SRC(4)) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_a)
  );

  oled_frame_arbiter #(.NUM_SRC(3)) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_b)
  );

  // 6.25 MHz pixel clock
  initial clock = 1'b0;
  always #80 clock = ~clock;

  logic [15:0] srcv [4];
  localparam logic [15:0] SRCB0 = 16'h3333;
  localparam logic [15:0] SRCB1 = 16'h2222;
  localparam logic [15:0] SRCB2 = 16'h1111;

  assign bus_a.src_data = {srcv[3], srcv[2], srcv[1], srcv[0]};
  assign bus_b.src_data = {SRCB2, SRCB1, SRCB0};

  // Bench view of what the screen should show
  int b_cur, b_nxt, b_bnd;
  bit b_wipe;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] exp_pix(input int col);
    int s;
    s = (b_wipe && (col < b_bnd)) ? b_nxt : b_cur;
    return srcv[s];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one pixel index, then compare the registered pixel next cycle
  task automatic drive_pix(input int idx);
    logic [15:0] e;
    bus_a.pixel_index = 13'(idx);
    exp_q.push_back(exp_pix(idx % 96));
    tick();
    e = exp_q.pop_front();
    chk($sformatf("pixel idx=%0d", idx), 32'(bus_a.pixel_data), 32'(e));
  endtask

  task automatic sweep(input int row);
    for (int c = 0; c < 96; c++) drive_pix(row * 96 + c);
  endtask

  task automatic frame();
    bus_a.frame_begin = 1'b1;
    bus_b.frame_begin = 1'b1;
    tick();
    bus_a.frame_begin = 1'b0;
    bus_b.frame_begin = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus_a.frame_begin = 1'b0; bus_a.pixel_index = '0; bus_a.sel = '0; bus_a.mode = 1'b0;
    bus_b.frame_begin = 1'b0; bus_b.pixel_index = '0; bus_b.sel = '0; bus_b.mode = 1'b0;
    srcv[0] = 16'hF800; srcv[1] = 16'h001F; srcv[2] = 16'h07E0; srcv[3] = 16'hF81F;
    b_cur = 0; b_nxt = 0; b_bnd = 0; b_wipe = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_pixel", 32'(bus_a.pixel_data), 32'h0);
    chk("rst_active", 32'(bus_a.active_src), 32'd0);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_done", 32'(bus_a.switch_done), 32'd0);
    reset_n = 1'b1;
    drive_pix(5);

    // Cut switch 0 -> 2 requested mid-frame
    drive_pix(100); drive_pix(101);
    bus_a.sel = 2'd2;
    tick();
    chk("cut_busy", 32'(bus_a.busy), 32'd1);
    chk("cut_active_hold", 32'(bus_a.active_src), 32'd0);
    sweep(10);
    frame();
    chk("cut_done", 32'(bus_a.switch_done), 32'd1);
    chk("cut_active", 32'(bus_a.active_src), 32'd2);
    chk("cut_busy_clr", 32'(bus_a.busy), 32'd0);
    b_cur = 2;
    drive_pix(0);
    chk("cut_done_once", 32'(bus_a.switch_done), 32'd0);
    sweep(0);
    sweep(63);

    // Back to source 0 by cut, then wipe 0 -> 1
    bus_a.sel = 2'd0;
    tick();
    frame();
    chk("back0_active", 32'(bus_a.active_src), 32'd0);
    b_cur = 0;
    srcv[0] = 16'h0000; srcv[1] = 16'hFFFF;
    bus_a.mode = 1'b1;
    bus_a.sel  = 2'd1;
    tick();
    chk("wipe_pend_busy", 32'(bus_a.busy), 32'd1);
    bus_a.mode = 1'b0;            // must not matter once the request is latched
    frame();
    chk("wipe_start_done", 32'(bus_a.switch_done), 32'd0);
    chk("wipe_start_busy", 32'(bus_a.busy), 32'd1);
    b_wipe = 1'b1; b_nxt = 1; b_bnd = 0;
    sweep(20);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) bus_a.sel = 2'd3;   // ignored while the wipe runs
      frame();
      if (k < 12) begin
        b_bnd = 8 * k;
        chk($sformatf("wipe_f%0d_done", k), 32'(bus_a.switch_done), 32'd0);
        chk($sformatf("wipe_f%0d_busy", k), 32'(bus_a.busy), 32'd1);
        sweep(20 + k);
      end else begin
        chk("wipe_end_done", 32'(bus_a.switch_done), 32'd1);
        chk("wipe_end_active", 32'(bus_a.active_src), 32'd1);
        chk("wipe_end_busy", 32'(bus_a.busy), 32'd0);
        b_cur = 1; b_wipe = 1'b0; b_bnd = 0;
      end
    end

    // The request made during the wipe is taken up afterwards as a cut
    sweep(40);
    chk("post_wipe_pend", 32'(bus_a.busy), 32'd1);
    chk("post_wipe_active", 32'(bus_a.active_src), 32'd1);
    frame();
    chk("post_wipe_done", 32'(bus_a.switch_done), 32'd1);
    chk("post_wipe_active3", 32'(bus_a.active_src), 32'd3);
    b_cur = 3;
    sweep(41);

    // Latest request wins: 0 -> 3 -> 1 before the frame boundary
    bus_a.sel = 2'd0;
    tick();
    frame();
    b_cur = 0;
    bus_a.sel = 2'd3;
    tick();
    chk("lw_busy", 32'(bus_a.busy), 32'd1);
    bus_a.sel = 2'd1;
    tick();
    frame();
    chk("lw_done", 32'(bus_a.switch_done), 32'd1);
    chk("lw_active", 32'(bus_a.active_src), 32'd1);
    b_cur = 1;
    sweep(50);

    // Cancel: request then return to the current source
    bus_a.sel = 2'd2;
    tick();
    chk("cancel_busy", 32'(bus_a.busy), 32'd1);
    bus_a.sel = 2'd1;
    tick();
    chk("cancel_busy_clr", 32'(bus_a.busy), 32'd0);
    frame();
    chk("cancel_no_done", 32'(bus_a.switch_done), 32'd0);
    chk("cancel_active", 32'(bus_a.active_src), 32'd1);

    // Request in the same cycle as frame_begin only enters pending
    bus_a.sel = 2'd2;
    frame();
    chk("simul_no_done", 32'(bus_a.switch_done), 32'd0);
    chk("simul_busy", 32'(bus_a.busy), 32'd1);
    chk("simul_active", 32'(bus_a.active_src), 32'd1);
    frame();
    chk("simul_done", 32'(bus_a.switch_done), 32'd1);
    chk("simul_active2", 32'(bus_a.active_src), 32'd2);
    b_cur = 2;

    // Reset in the middle of a wipe 2 -> 3 at boundary 40
    srcv[0] = 16'h001F;
    bus_a.mode = 1'b1;
    bus_a.sel  = 2'd3;
    tick();
    frame();
    b_wipe = 1'b1; b_nxt = 3; b_bnd = 0;
    for (int k = 1; k <= 5; k++) begin
      frame();
      b_bnd = 8 * k;
    end
    sweep(60);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("mid_rst_active", 32'(bus_a.active_src), 32'd0);
    chk("mid_rst_pixel", 32'(bus_a.pixel_data), 32'h0);
    chk("mid_rst_done", 32'(bus_a.switch_done), 32'd0);
    tick();
    bus_a.sel = 2'd0; bus_a.mode = 1'b0;
    reset_n = 1'b1;
    b_cur = 0; b_wipe = 1'b0; b_bnd = 0;
    drive_pix(39);
    drive_pix(7);
    frame();
    chk("after_rst_done", 32'(bus_a.switch_done), 32'd0);
    chk("after_rst_busy", 32'(bus_a.busy), 32'd0);

    // Invalid selector on the three-source arbiter
    bus_b.sel = 2'd3;
    tick();
    tick();
    chk("inv_busy", 32'(bus_b.busy), 32'd0);
    frame();
    chk("inv_active", 32'(bus_b.active_src), 32'd0);
    chk("inv_done", 32'(bus_b.switch_done), 32'd0);
    chk("inv_pixel", 32'(bus_b.pixel_data), 32'(SRCB0));
    bus_b.sel = 2'd2;
    tick();
    chk("b_busy", 32'(bus_b.busy), 32'd1);
    frame();
    chk("b_done", 32'(bus_b.switch_done), 32'd1);
    chk("b_active", 32'(bus_b.active_src), 32'd2);
    tick();
    chk("b_pixel", 32'(bus_b.pixel_data), 32'(SRCB2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
